// File: rtl/bin2dec_seq.sv
// Sequential binary-to-radix converter: repeated restoring division by RADIX,
// one quotient bit per clock, one output digit every WIDTH clocks.
module bin2dec_seq #(
    parameter int WIDTH  = 30,
    parameter int RADIX  = 10,
    parameter int DIGITS = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DIGITS*$clog2(RADIX)-1:0]       out_digits,
    output logic                                  out_ovf,
    output logic                                  busy
);

    localparam int RW = $clog2(RADIX);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [RW:0] RADIX_T = (RW + 1)'(RADIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [WIDTH-1:0]         r_dividend;
    logic [RW-1:0]            r_rem;
    logic [CW-1:0]            r_bitcnt;
    logic [IW-1:0]            r_idx;
    logic [DIGITS*RW-1:0]     r_digits;
    logic                     r_ovf;

    logic [RW:0]              w_t;
    logic                     w_q;
    logic [RW-1:0]            w_rem_next;
    logic [WIDTH-1:0]         w_div_next;

    // One restoring step: the remainder stays below RADIX, so it always fits in RW bits.
    assign w_t        = {r_rem, r_dividend[WIDTH-1]};
    assign w_q        = (w_t >= RADIX_T);
    assign w_rem_next = w_q ? RW'(w_t - RADIX_T) : w_t[RW-1:0];
    assign w_div_next = {r_dividend[WIDTH-2:0], w_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_rem      <= '0;
            r_bitcnt   <= '0;
            r_idx      <= '0;
            r_digits   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dividend <= in_data;
                        r_rem      <= '0;
                        r_bitcnt   <= CW'(WIDTH - 1);
                        r_idx      <= '0;
                        r_digits   <= '0;
                        r_ovf      <= 1'b0;
                        r_state    <= DIV;
                    end
                end
                DIV: begin
                    r_dividend <= w_div_next;
                    // Last bit of a division: the remainder is the digit, the quotient feeds the next one.
                    if (r_bitcnt == '0) begin
                        r_digits[r_idx*RW +: RW] <= w_rem_next;
                        r_rem    <= '0;
                        r_bitcnt <= CW'(WIDTH - 1);
                        r_idx    <= r_idx + IW'(1);
                        if (r_idx == IW'(DIGITS - 1)) begin
                            r_ovf   <= |w_div_next;
                            r_state <= DONE;
                        end
                    end else begin
                        r_rem    <= w_rem_next;
                        r_bitcnt <= r_bitcnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state == DIV);
    assign out_valid  = (r_state == DONE);
    assign out_digits = r_digits;
    assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_bin2dec_seq.sv
// Self-checking bench for bin2dec_seq: three parameterisations checked against
// a repeated-division reference model.
module tb_bin2dec_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance: WIDTH=30, RADIX=10, DIGITS=10
    logic        v0 = 0, or0 = 0, rdy0, ov0, ovf0, busy0;
    logic [29:0] d0 = '0;
    logic [39:0] dig0;
    // DIGITS=3
    logic        v1 = 0, or1 = 0, rdy1, ov1, ovf1, busy1;
    logic [29:0] d1 = '0;
    logic [11:0] dig1;
    // RADIX=8, DIGITS=3
    logic        v2 = 0, or2 = 0, rdy2, ov2, ovf2, busy2;
    logic [29:0] d2 = '0;
    logic [8:0]  dig2;

    int n_tests = 0;
    int n_fail  = 0;

    bin2dec_seq #(.WIDTH(30), .RADIX(10), .DIGITS(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .out_digits(dig0), .out_ovf(ovf0), .busy(busy0));
    bin2dec_seq #(.WIDTH(30), .RADIX(10), .DIGITS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_digits(dig1), .out_ovf(ovf1), .busy(busy1));
    bin2dec_seq #(.WIDTH(30), .RADIX(8), .DIGITS(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_digits(dig2), .out_ovf(ovf2), .busy(busy2));

    // Reference: peel digits off with % and /, whatever is left over is overflow.
    function automatic logic [63:0] model(input longint unsigned v, input int radix,
                                          input int digits, input int rw, output logic ovf);
        logic [63:0] r;
        longint unsigned q;
        r = '0;
        q = v;
        for (int k = 0; k < digits; k++) begin
            r = r | (64'(q % longint'(radix)) << (k * rw));
            q = q / longint'(radix);
        end
        ovf = (q != 0);
        return r;
    endfunction

    // Edges from the acceptance edge (already passed) until out_valid rises.
    task automatic wait0(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov0 && lat < 400);
    endtask

    task automatic run0(input logic [29:0] val, output int lat);
        @(negedge clk); v0 = 1; d0 = val;
        @(posedge clk); #1;
        @(negedge clk); v0 = 0; d0 = 30'($urandom);
        wait0(lat);
    endtask

    task automatic release0();
        @(negedge clk); or0 = 1;
        @(posedge clk); #1;
        @(negedge clk); or0 = 0;
    endtask

    task automatic run1(input logic [29:0] val, output int lat);
        @(negedge clk); v1 = 1; d1 = val;
        @(posedge clk); #1;
        @(negedge clk); v1 = 0; d1 = 30'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov1 && lat < 200);
    endtask

    task automatic run2(input logic [29:0] val, output int lat);
        @(negedge clk); v2 = 1; d2 = val;
        @(posedge clk); #1;
        @(negedge clk); v2 = 0; d2 = 30'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov2 && lat < 200);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
        n_tests++;
        if (ov0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy got %b%b want 00", ov0, busy0);
        end
        n_tests++;
        if (dig0 !== 40'h0 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got %h/%b want 0/0", dig0, ovf0);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_known_values();
        int lat;
        run0(30'd0, lat);
        n_tests++;
        if (lat !== 300) begin n_fail++; $display("FAIL zero_latency got %0d want 300", lat); end
        n_tests++;
        if (dig0 !== 40'h0 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL zero_digits got %h/%b want 0/0", dig0, ovf0);
        end
        release0();
        run0(30'd1073741823, lat);
        n_tests++;
        if (lat !== 300) begin n_fail++; $display("FAIL max_latency got %0d want 300", lat); end
        n_tests++;
        if (dig0 !== 40'h1073741823 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL max_digits got %h/%b want 1073741823/0", dig0, ovf0);
        end
        release0();
    endtask

    task automatic test_random_default();
        int lat;
        logic [29:0] val;
        logic [63:0] exp;
        logic eovf;
        for (int i = 0; i < 8; i++) begin
            val = 30'($urandom);
            exp = model(longint'(val), 10, 10, 4, eovf);
            run0(val, lat);
            n_tests++;
            if (lat !== 300 || dig0 !== exp[39:0] || ovf0 !== eovf) begin
                n_fail++;
                $display("FAIL rand_default in=%0d got %h/%b lat %0d want %h/%b lat 300",
                         val, dig0, ovf0, lat, exp[39:0], eovf);
            end
            release0();
        end
    endtask

    task automatic test_small_digits();
        int lat;
        logic [29:0] val;
        logic [63:0] exp;
        logic eovf;
        run1(30'd1234, lat);
        n_tests++;
        if (lat !== 90 || dig1 !== 12'h234 || ovf1 !== 1'b1) begin
            n_fail++; $display("FAIL d3_1234 got %h/%b lat %0d want 234/1 lat 90", dig1, ovf1, lat);
        end
        @(negedge clk); or1 = 1; @(posedge clk); #1; @(negedge clk); or1 = 0;
        for (int i = 0; i < 6; i++) begin
            val = (i < 3) ? 30'($urandom_range(0, 999)) : 30'($urandom);
            exp = model(longint'(val), 10, 3, 4, eovf);
            run1(val, lat);
            n_tests++;
            if (lat !== 90 || dig1 !== exp[11:0] || ovf1 !== eovf) begin
                n_fail++;
                $display("FAIL d3_rand in=%0d got %h/%b lat %0d want %h/%b lat 90",
                         val, dig1, ovf1, lat, exp[11:0], eovf);
            end
            @(negedge clk); or1 = 1; @(posedge clk); #1; @(negedge clk); or1 = 0;
        end
    endtask

    task automatic test_radix8();
        int lat;
        logic [29:0] val;
        logic [63:0] exp;
        logic eovf;
        run2(30'd511, lat);
        n_tests++;
        if (lat !== 90 || dig2 !== 9'o777 || ovf2 !== 1'b0) begin
            n_fail++; $display("FAIL r8_511 got %o/%b lat %0d want 777/0 lat 90", dig2, ovf2, lat);
        end
        @(negedge clk); or2 = 1; @(posedge clk); #1; @(negedge clk); or2 = 0;
        for (int i = 0; i < 4; i++) begin
            val = (i < 2) ? 30'($urandom_range(0, 511)) : 30'($urandom);
            exp = model(longint'(val), 8, 3, 3, eovf);
            run2(val, lat);
            n_tests++;
            if (dig2 !== exp[8:0] || ovf2 !== eovf) begin
                n_fail++;
                $display("FAIL r8_rand in=%0d got %o/%b want %o/%b", val, dig2, ovf2, exp[8:0], eovf);
            end
            @(negedge clk); or2 = 1; @(posedge clk); #1; @(negedge clk); or2 = 0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [29:0] val, nv;
        logic [63:0] exp;
        logic eovf;
        logic [39:0] held;
        logic held_ovf;
        val = 30'($urandom);
        exp = model(longint'(val), 10, 10, 4, eovf);
        run0(val, lat);
        n_tests++;
        if (dig0 !== exp[39:0] || ovf0 !== eovf) begin
            n_fail++; $display("FAIL bp_result got %h/%b want %h/%b", dig0, ovf0, exp[39:0], eovf);
        end
        held = dig0;
        held_ovf = ovf0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); v0 = 1'($urandom_range(0, 1)); d0 = 30'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if (ov0 !== 1'b1 || rdy0 !== 1'b0 || busy0 !== 1'b0 || dig0 !== held || ovf0 !== held_ovf) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got v%b r%b b%b %h/%b want v1 r0 b0 %h/%b",
                         i, ov0, rdy0, busy0, dig0, ovf0, held, held_ovf);
            end
        end
        nv = 30'($urandom_range(0, 99999));
        @(negedge clk); or0 = 1; v0 = 1; d0 = nv;
        @(posedge clk); #1;
        n_tests++;
        if (rdy0 !== 1'b1 || ov0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got r%b v%b b%b want r1 v0 b0", rdy0, ov0, busy0);
        end
        @(negedge clk); or0 = 0;
        @(posedge clk); #1;
        n_tests++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept got busy %b want 1", busy0); end
        @(negedge clk); v0 = 0;
        wait0(lat);
        exp = model(longint'(nv), 10, 10, 4, eovf);
        n_tests++;
        if (lat !== 300 || dig0 !== exp[39:0] || ovf0 !== eovf) begin
            n_fail++;
            $display("FAIL bp_next_result got %h/%b lat %0d want %h/%b lat 300",
                     dig0, ovf0, lat, exp[39:0], eovf);
        end
        release0();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        @(negedge clk); v0 = 1; d0 = 30'($urandom);
        @(posedge clk); #1;
        @(negedge clk); v0 = 0;
        repeat (99) @(posedge clk);
        #1; rst_n = 0;
        #1;
        n_tests++;
        if (ov0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b0 || dig0 !== 40'h0 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got v%b r%b b%b %h/%b want v0 r1 b0 0/0", ov0, rdy0, busy0, dig0, ovf0);
        end
        @(negedge clk); rst_n = 1;
        run0(30'd42, lat);
        n_tests++;
        if (lat !== 300 || dig0 !== 40'h42 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_42 got %h/%b lat %0d want 42/0 lat 300", dig0, ovf0, lat);
        end
        release0();
    endtask

    initial begin
        test_reset();
        test_known_values();
        test_random_default();
        test_small_digits();
        test_radix8();
        test_backpressure();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2dec_seq.md
BIN2DEC_SEQ -- requirements
Module: bin2dec_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 30, binary input width in bits.
REQ-002 SHALL have parameter RADIX, default 10, output digit radix, legal range 2..64.
REQ-003 SHALL have parameter DIGITS, default 10, number of output digits produced.
REQ-004 SHALL derive localparam RW = ceil(log2(RADIX)), digit field width (4 for RADIX=10).
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  in_data offered.
REQ-009 in_ready  out  1  block can accept in_data.
REQ-010 in_data  in  WIDTH  unsigned binary value to convert.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes the result.
REQ-013 out_digits  out  DIGITS*RW  digit k in bits [k*RW +: RW], k=0 least significant.
REQ-014 out_ovf  out  1  value did not fit in DIGITS digits.
REQ-015 busy  out  1  conversion in progress.

Function
REQ-016 SHALL implement states IDLE, DIV, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in DIV; out_valid SHALL be 1 only in DONE.
REQ-018 Acceptance SHALL occur on an edge with state IDLE and in_valid=1: dividend <= in_data, remainder <= 0, bit counter <= WIDTH-1, digit index <= 0, state -> DIV.
REQ-019 Each DIV edge SHALL perform one restoring step: t = {remainder, dividend MSB}; if t >= RADIX then remainder <= t-RADIX and quotient bit = 1, else remainder <= t and quotient bit = 0; dividend shifts left, inserting the quotient bit at the LSB.
REQ-020 The remainder register SHALL be RW bits; t SHALL be RW+1 bits; remainder SHALL always be < RADIX.
REQ-021 After WIDTH steps, digit[index] SHALL equal the final remainder, dividend SHALL hold the quotient, remainder SHALL clear, and index SHALL increment.
REQ-022 After DIGITS digits, out_ovf SHALL be set iff the residual quotient is nonzero; state -> DONE on that same edge.
REQ-023 Latency SHALL be exactly DIGITS*WIDTH edges from the acceptance edge to the edge that raises out_valid (300 at defaults), independent of data.
REQ-024 In DONE, out_digits and out_ovf SHALL hold stable until the edge with out_ready=1, then state -> IDLE.
REQ-025 A new input SHALL NOT be accepted on the DONE->IDLE edge; the minimum acceptance spacing is DIGITS*WIDTH+2 edges.
REQ-026 in_data and in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-027 With out_ovf=1, out_digits SHALL equal in_data mod RADIX^DIGITS.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, busy=0, out_ovf=0, out_digits=0, all counters 0, regardless of the clock.
REQ-029 A reset during DIV or DONE SHALL abandon the conversion with no partial result visible.
REQ-030 After rst_n rises, the first edge with in_valid=1 SHALL be accepted.

Verification
REQ-031 Defaults, in_data=0 -> out_valid 300 edges after acceptance, all digits 0, out_ovf=0.
REQ-032 Defaults, in_data=1073741823 -> digits k9..k0 = 1,0,7,3,7,4,1,8,2,3; out_ovf=0.
REQ-033 DIGITS=3, in_data=1234 -> digits 2,3,4; out_ovf=1; latency 90.
REQ-034 RADIX=8, DIGITS=3, in_data=511 -> digits 7,7,7 (RW=3); out_ovf=0.
REQ-035 Backpressure: out_ready=0 for 50 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE on the next edge.
REQ-036 Reset mid-DIV at edge 100 -> out_valid=0 and in_ready=1 at once; a fresh conversion of 42 -> digits ...,0,4,2; out_ovf=0.
